// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage of the single-issue core. Holds the program counter,
// fetches one instruction word per instruction through a req/ack handshake
// with timeout-and-retry, hands the word to decode with a one-cycle
// IF_kick_up token, then waits for the retire token (WB_kick_up) before
// stepping the PC sequentially or to the resolved branch target. Only one
// instruction is ever in flight.
//
// Parameters:
//   RESET_PC       PC loaded on reset.
//   FETCH_TIMEOUT  FETCH cycles without ack before a retry (2..255).
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset          synchronous active-high reset
//   imem_req       fetch request, high only in FETCH
//   imem_addr      fetch address, always equal to pc
//   imem_ack       memory presents valid imem_rdata this cycle
//   imem_rdata     fetched instruction word
//   instruction    registered instruction word for decode
//   pc             address of the instruction being fetched or held
//   IF_kick_up     one-cycle token: instruction is new and valid
//   WB_kick_up     retire token from the last stage
//   branch_taken   sampled with WB_kick_up, selects branch_target
//   branch_target  next PC when branch_taken
//   fetch_fault    sticky misaligned-PC fault
//
// Configuration macro:
//   IF_MISALIGN_TRAP_EN  when defined, a misaligned next PC halts the stage
//                        and raises fetch_fault; when undefined the next PC
//                        is force-aligned and fetch_fault is tied low.
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        IF_kick_up,
  input  logic        WB_kick_up,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    RETRY = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    HALT  = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  timeout_cnt;
  logic [31:0] next_pc;

  // Candidate PC for the WAIT exit; the +4 wraps naturally modulo 2^32.
  assign next_pc = branch_taken ? branch_target : (pc + 32'd4);

  // The request is a pure decode of the state register, so a reset always
  // drops it on the same edge the state returns to IDLE.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

`ifdef IF_MISALIGN_TRAP_EN
  logic fault_q;
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Main fetch sequencer. IF_kick_up is registered and raised on the edge
  // that accepts the ack, so it is high exactly during the ISSUE cycle.
  // An ack that lands on the last timeout cycle is still accepted because
  // the ack test comes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= 32'h0000_0000;
      IF_kick_up  <= 1'b0;
      timeout_cnt <= 8'd0;
`ifdef IF_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      IF_kick_up <= 1'b0;
      case (state)
        IDLE: begin
          state <= FETCH;
        end

        FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            timeout_cnt <= 8'd0;
            IF_kick_up  <= 1'b1;
            state       <= ISSUE;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            timeout_cnt <= 8'd0;
            state       <= RETRY;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
          end
        end

        // One idle cycle with the request dropped; a late ack is discarded.
        RETRY: begin
          state <= FETCH;
        end

        ISSUE: begin
          state <= WAIT;
        end

        WAIT: begin
          if (WB_kick_up) begin
`ifdef IF_MISALIGN_TRAP_EN
            pc <= next_pc;
            if (next_pc[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              state   <= HALT;
            end else begin
              state <= FETCH;
            end
`else
            pc    <= {next_pc[31:2], 2'b00};
            state <= FETCH;
`endif
          end
        end

        // Parked until reset; every output holds its value.
        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
//
// Directed testbench for if_fetch with FETCH_TIMEOUT = 4 and RESET_PC = 0.
// Inputs are driven 1 time unit after each rising edge and outputs are
// checked at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_if_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        IF_kick_up;
  logic        WB_kick_up;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fetch_fault;

  int nAsserts = 0;
  int nFails   = 0;

  if_fetch #(
    .RESET_PC      (32'h0000_0000),
    .FETCH_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc            (pc),
    .IF_kick_up    (IF_kick_up),
    .WB_kick_up    (WB_kick_up),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fetch_fault   (fetch_fault)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts and reports via immediate assertion.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive all handshake/retire inputs for the coming cycle.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic wb, input logic taken,
                               input logic [31:0] target);
    imem_ack      = ack;
    imem_rdata    = rdata;
    WB_kick_up    = wb;
    branch_taken  = taken;
    branch_target = target;
  endtask

  // From a FETCH cycle: ack immediately, check the ISSUE cycle, land in WAIT.
  task automatic fetchAck(input string tag, input logic [31:0] word);
    applyStimulus(1'b1, word, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_kick"}, {31'b0, IF_kick_up}, 32'd1);
    checkOutput({tag, "_instr"}, instruction, word);
    step();
  endtask

  // From WAIT: retire with the given branch outcome, land in the next state.
  task automatic retire(input logic taken, input logic [31:0] target);
    applyStimulus(1'b0, 32'h0, 1'b1, taken, target);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Reset values.
    checkOutput("rst_pc",    pc,                        32'h0);
    checkOutput("rst_req",   {31'b0, imem_req},         32'd0);
    checkOutput("rst_instr", instruction,               32'h0);
    checkOutput("rst_kick",  {31'b0, IF_kick_up},       32'd0);
    checkOutput("rst_fault", {31'b0, fetch_fault},      32'd0);

    // Release: IDLE this cycle, FETCH next.
    reset = 1'b0;
    checkOutput("idle_req", {31'b0, imem_req}, 32'd0);
    step();
    checkOutput("first_req",  {31'b0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr,         32'h0);
    fetchAck("first", 32'h0000_0013);
    checkOutput("wait_kick", {31'b0, IF_kick_up}, 32'd0);
    checkOutput("wait_req",  {31'b0, imem_req},   32'd0);
    step();
    checkOutput("wait_hold_pc",    pc,          32'h0);
    checkOutput("wait_hold_instr", instruction, 32'h0000_0013);

    // Taken branch to 0x10.
    retire(1'b1, 32'h0000_0010);
    checkOutput("br10_req",  {31'b0, imem_req}, 32'd1);
    checkOutput("br10_addr", imem_addr,         32'h10);

    // WB_kick_up during FETCH is ignored.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
    step();
    checkOutput("wb_in_fetch_pc", pc, 32'h10);
    applyStimulus(1'b1, 32'h0000_AAAA, 1'b0, 1'b0, 32'h0);
    step();
    // WB_kick_up during ISSUE is ignored.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
    checkOutput("issue_kick", {31'b0, IF_kick_up}, 32'd1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wb_in_issue_pc", pc, 32'h10);

    // Not taken at 0x10 -> 0x14.
    retire(1'b0, 32'h0000_0080);
    checkOutput("seq14_addr", imem_addr,         32'h14);
    checkOutput("seq14_req",  {31'b0, imem_req}, 32'd1);

    // No ack: request high 4 cycles, low 1, then high again at same address.
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_req%0d", i), {31'b0, imem_req}, 32'd1);
      checkOutput($sformatf("to_addr%0d", i), imem_addr, 32'h14);
      step();
    end
    checkOutput("retry_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("refetch_req",   {31'b0, imem_req}, 32'd1);
    checkOutput("refetch_addr",  imem_addr,         32'h14);
    checkOutput("retry_ack_ign", instruction,       32'h0000_AAAA);
    checkOutput("retry_no_kick", {31'b0, IF_kick_up}, 32'd0);
    fetchAck("second", 32'h0000_1234);
    checkOutput("second_single", {31'b0, IF_kick_up}, 32'd0);

    // Ack coincides with timeout expiry: goes to ISSUE, not RETRY.
    retire(1'b0, 32'h0);
    checkOutput("seq18_addr", imem_addr, 32'h18);
    step();
    step();
    step();
    applyStimulus(1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("coinc_kick",  {31'b0, IF_kick_up}, 32'd1);
    checkOutput("coinc_instr", instruction,         32'h0000_0055);
    step();
    checkOutput("coinc_wait_req", {31'b0, imem_req}, 32'd0);

    // PC wrap: 0xFFFF_FFFC + 4 -> 0.
    retire(1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    fetchAck("wrap", 32'h0000_0077);
    retire(1'b0, 32'h0);
    checkOutput("wrap_addr", imem_addr,         32'h0);
    checkOutput("wrap_req",  {31'b0, imem_req}, 32'd1);

    // Reset mid-FETCH with an ack pending.
    fetchAck("pre_rst", 32'h0000_0033);
    retire(1'b1, 32'h0000_0040);
    checkOutput("pre_rst_addr", imem_addr, 32'h40);
    applyStimulus(1'b1, 32'h0000_0099, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("midrst_pc",    pc,                  32'h0);
    checkOutput("midrst_req",   {31'b0, imem_req},   32'd0);
    checkOutput("midrst_instr", instruction,         32'h0);
    checkOutput("midrst_kick",  {31'b0, IF_kick_up}, 32'd0);
    step();
    checkOutput("postrst_req", {31'b0, imem_req}, 32'd1);

    // Taken branch to misaligned 0x42.
    fetchAck("mis", 32'h0000_0013);
    retire(1'b1, 32'h0000_0042);
`ifdef IF_MISALIGN_TRAP_EN
    checkOutput("mis_fault", {31'b0, fetch_fault}, 32'd1);
    checkOutput("mis_pc",    pc,                   32'h42);
    checkOutput("mis_req",   {31'b0, imem_req},    32'd0);
    applyStimulus(1'b1, 32'h0000_0011, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("halt_req%0d", i), {31'b0, imem_req}, 32'd0);
      checkOutput($sformatf("halt_kick%0d", i), {31'b0, IF_kick_up}, 32'd0);
      checkOutput($sformatf("halt_pc%0d", i), pc, 32'h42);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
`else
    checkOutput("align_pc",    pc,                   32'h40);
    checkOutput("align_req",   {31'b0, imem_req},    32'd1);
    checkOutput("align_fault", {31'b0, fetch_fault}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the single-issue core, directly upstream of the decode stage. Holds the program counter, fetches one word per instruction from instruction memory through a req/ack handshake with timeout-and-retry, presents the word to decode with a one-cycle `IF_kick_up` token, then waits for the retire token from the last stage before computing the next PC, which is either sequential or the resolved branch target. Exactly one instruction is in flight at a time.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `FETCH_TIMEOUT`, 16, FETCH cycles without ack before a retry; legal range 2..255.

Ports:
- `clk`  in  1  clock; all state on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; high only in FETCH.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ack`  in  1  memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched word.
- `instruction`  out  32  registered instruction word for decode.
- `pc`  out  32  address of the instruction being fetched or held.
- `IF_kick_up`  out  1  one-cycle token: `instruction` is new and valid.
- `WB_kick_up`  in  1  retire token; the current instruction has completed.
- `branch_taken`  in  1  sampled with `WB_kick_up`; select the branch target.
- `branch_target`  in  32  next PC when `branch_taken`.
- `fetch_fault`  out  1  sticky misaligned-PC fault (see Configuration).

## Operation
- States: IDLE, FETCH, RETRY, ISSUE, WAIT, HALT.
- Reset: state IDLE, `pc`=`RESET_PC`, `instruction`=0, `IF_kick_up`=0, `fetch_fault`=0, timeout counter=0. `imem_req`=0 because it is decoded from state.
- IDLE -> FETCH unconditionally on the next cycle.
- FETCH: `imem_req`=1. If `imem_ack`=1, then `instruction`<=`imem_rdata`, counter<=0, and the state goes to ISSUE. Otherwise the counter increments. When the counter reaches `FETCH_TIMEOUT`-1 with no ack, the state goes to RETRY and the counter clears.
- Ack and timeout expiry in the same cycle: ack wins.
- RETRY: `imem_req`=0 for exactly one cycle, then FETCH at the same `pc`. An `imem_ack` that arrives during RETRY is ignored.
- ISSUE: `IF_kick_up`=1 for exactly this cycle, then WAIT.
- WAIT: `instruction` and `pc` are held stable. On `WB_kick_up`=1, `pc`<=`branch_taken` ? `branch_target` : `pc`+4, and the state goes to FETCH.
- `pc`+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 0.
- `WB_kick_up` is ignored in every state except WAIT.
- `instruction` changes only on an accepted ack. `pc` changes only on reset or on the WAIT exit.
- `reset` in any state, mid-handshake included, returns everything to reset values on that edge. The memory must tolerate a dropped request.

## Timing
- Ack sampled in cycle N: `instruction` is valid from N+1, and `IF_kick_up` is high in N+1 only.
- Minimum loop with zero-wait memory:
  - FETCH (ack) -> ISSUE -> WAIT (`WB_kick_up`) -> FETCH.
  - That is 3 cycles per instruction plus the downstream latency.
- `WB_kick_up` in cycle M: the new `pc`/`imem_addr` is visible and `imem_req`=1 in M+1.
- First request after reset: `reset` low in cycle R, then IDLE in R and FETCH (`imem_req`=1) in R+1.
- Retry: with no ack, `imem_req` is high for `FETCH_TIMEOUT` cycles, low 1 cycle, then high again.

## Configuration
- Macro `IF_MISALIGN_TRAP_EN`.
- Defined:
  - At the WAIT exit, a next PC with bits [1:0]≠0 goes to HALT instead of FETCH.
  - `pc` is loaded with the offending value and `fetch_fault`<=1 (sticky).
  - HALT holds all outputs with `imem_req`=0 and `IF_kick_up`=0 until `reset`.
- Undefined:
  - The next PC is loaded with bits [1:0] forced to 0.
  - HALT is unreachable and `fetch_fault` is tied 0.

## Test plan
- Reset release, memory acks on the first request cycle with 32'h0000_0013 -> `imem_addr`=0, `IF_kick_up` pulse one cycle later, `instruction`=32'h0000_0013.
- `WB_kick_up`=1 with `branch_taken`=0 at `pc`=0x10 -> next request at 0x14. Repeat with `branch_taken`=1, `branch_target`=0x40 -> request at 0x40. Also `pc`=32'hFFFF_FFFC, not taken -> 0.
- Memory never acks, `FETCH_TIMEOUT`=4 -> `imem_req` high 4 cycles, low 1, high again at the same address. Ack on the 2nd attempt -> a single `IF_kick_up`.
- `WB_kick_up` pulsed during FETCH and ISSUE -> no PC change. Ack and timeout coinciding -> ISSUE, no RETRY.
- `reset` asserted mid-FETCH with ack pending -> next cycle `pc`=`RESET_PC`, `imem_req`=0, `instruction`=0.
- Taken branch to 0x42:
  - With `IF_MISALIGN_TRAP_EN` -> `fetch_fault`=1, `pc`=0x42, no further requests.
  - Without it -> fetch at 0x40.
